// File: rtl/constraint_sampler.sv
// Rejection sampler: fills a CAND_W-bit candidate from a 64-bit Fibonacci LFSR,
// one word per cycle, and retries until the external checker accepts or MAX_TRIES run out.

module cs_word #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module constraint_sampler #(
  parameter int          CAND_W    = 506,
  parameter logic [63:0] SEED      = 64'h1,
  parameter logic [31:0] MAX_TRIES = 32'd1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [CAND_W-1:0] cand,
  input  logic              sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CAND_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [31:0]       tries
);
  localparam int          NW       = (CAND_W + 63) / 64;
  localparam int          KW       = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [63:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

  typedef enum logic [1:0] {IDLE, FILL, CHECK, HOLD} state_t;
  state_t state, state_nxt;

  logic [63:0]   lfsr, lfsr_nxt;
  logic [KW-1:0] k;
  logic          fill_we, last_try;

  assign lfsr_nxt = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
  assign fill_we  = (state == FILL);
  // 33-bit compare so MAX_TRIES = 2^32-1 cannot wrap
  assign last_try = ({1'b0, tries} + 33'd1) >= {1'b0, MAX_TRIES};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    out_valid = 1'b0;
    done      = 1'b0;
    fail      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FILL;
      end
      FILL:  if (k == K_LAST) state_nxt = CHECK;
      CHECK: begin
        if (sat) state_nxt = HOLD;
        else if (last_try) begin
          fail      = 1'b1;
          state_nxt = IDLE;
        end else state_nxt = FILL;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= SEED_EFF;
      k        <= '0;
      tries    <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          tries <= '0;
          k     <= '0;
        end
        FILL: begin
          lfsr <= lfsr_nxt;
          k    <= (k == K_LAST) ? '0 : k + KW'(1);
        end
        CHECK: begin
          if (tries != '1) tries <= tries + 32'd1;
          if (sat)         out_data <= cand;
        end
        default: ;
      endcase
    end
  end

  // One register slice per 64-bit word; the top word keeps only the bits below CAND_W
  for (genvar w = 0; w < NW; w++) begin : g_word
    localparam int LO = 64 * w;
    localparam int WW = ((CAND_W - LO) > 64) ? 64 : (CAND_W - LO);
    cs_word #(.W(WW)) u_word (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (fill_we && (k == KW'(w))),
      .d    (lfsr[WW-1:0]),
      .q    (cand[LO+WW-1:LO])
    );
  end
endmodule

// File: tb/tb_constraint_sampler.sv
// Bench for constraint_sampler: transaction-level model (whole candidates drawn from the
// LFSR sequence at once) compared every cycle, plus literal pins on known sequence values.
module tb_constraint_sampler;
  localparam int     CW1 = 506, CW2 = 70;
  localparam longint MT1 = 1024, MT2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, st1, sat1, rdy1, ov1, busy1, dn1, fl1;
  logic rst2, st2, sat2, rdy2, ov2, busy2, dn2, fl2;
  logic [CW1-1:0] cand1, od1;
  logic [CW2-1:0] cand2, od2;
  logic [31:0] tr1, tr2;

  constraint_sampler dut1 (
    .clk(clk), .rst_n(rst1), .start(st1), .cand(cand1), .sat(sat1),
    .out_valid(ov1), .out_ready(rdy1), .out_data(od1), .busy(busy1),
    .done(dn1), .fail(fl1), .tries(tr1));

  constraint_sampler #(.CAND_W(CW2), .SEED(64'h0), .MAX_TRIES(32'd4)) dut2 (
    .clk(clk), .rst_n(rst2), .start(st2), .cand(cand2), .sat(sat2),
    .out_valid(ov2), .out_ready(rdy2), .out_data(od2), .busy(busy2),
    .done(dn2), .fail(fl2), .tries(tr2));

  int pass_cnt = 0, chk_cnt = 0, cyc = 0;
  int dn1_cnt, fl1_cyc, fl2_cyc, ov2_seen;
  logic [63:0] od_hist [8];

  // st: 0 idle, 1 fill, 2 check, 3 hold
  typedef struct {
    int           st;
    int           fill_left;
    logic [63:0]  lfsr;
    logic [31:0]  tries;
    logic [1023:0] cand;
    logic [1023:0] ncand;
    logic [1023:0] odata;
    bit           known;
  } m_t;
  m_t m1, m2;

  function automatic logic [63:0] lfsr_nxt(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk_w(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else begin
      int w;
      w = 0;
      for (int i = 15; i >= 0; i--) if (act[64*i +: 64] !== exp[64*i +: 64]) w = i;
      $display("FAIL %s: word %0d got %h, expected %h (cycle %0d)", nm, w,
               act[64*w +: 64], exp[64*w +: 64], cyc);
    end
  endtask

  task automatic m_rst(output m_t m, input logic [63:0] seed);
    m.st = 0; m.fill_left = 0; m.lfsr = (seed == 64'd0) ? 64'h1 : seed;
    m.tries = '0; m.cand = '0; m.ncand = '0; m.odata = '0; m.known = 1'b1;
  endtask

  // Draw a whole candidate from the sequence; the DUT exposes it after the fill cycles
  task automatic m_new_cand(inout m_t m, input int cw);
    int nw;
    nw = (cw + 63) / 64;
    m.ncand = '0;
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 64; b++) if (64*w + b < cw) m.ncand[64*w + b] = m.lfsr[b];
      m.lfsr = lfsr_nxt(m.lfsr);
    end
    m.fill_left = nw; m.known = 1'b0; m.st = 1;
  endtask

  task automatic m_step(inout m_t m, input int cw, input longint mt,
                        input bit s, input bit sat, input bit rdy);
    case (m.st)
      0: if (s) begin m.tries = '0; m_new_cand(m, cw); end
      1: begin
        m.fill_left--;
        if (m.fill_left == 0) begin m.st = 2; m.cand = m.ncand; m.known = 1'b1; end
      end
      2: begin
        longint nt;
        nt = longint'(m.tries) + 1;
        if (m.tries != 32'hFFFF_FFFF) m.tries++;
        if (sat) begin m.st = 3; m.odata = m.cand; end
        else if (nt >= mt) m.st = 0;
        else m_new_cand(m, cw);
      end
      3: if (rdy) m.st = 0;
      default: m.st = 0;
    endcase
  endtask

  task automatic m_cmp(input string t, input m_t m, input longint mt, input bit sat, input bit rdy,
                       input logic busy, input logic ov, input logic dn, input logic fl,
                       input logic [31:0] tr, input logic [1023:0] c, input logic [1023:0] od);
    chk({t, ".busy"},      64'(busy), 64'(m.st != 0));
    chk({t, ".out_valid"}, 64'(ov),   64'(m.st == 3));
    chk({t, ".done"},      64'(dn),   64'(m.st == 3 && rdy));
    chk({t, ".fail"},      64'(fl),   64'(m.st == 2 && !sat && (longint'(m.tries) + 1 >= mt)));
    chk({t, ".tries"},     64'(tr),   64'(m.tries));
    chk_w({t, ".out_data"}, od, m.odata);
    if (m.known) chk_w({t, ".cand"}, c, m.cand);
  endtask

  task automatic step();
    #1;
    m_cmp("d1", m1, MT1, sat1, rdy1, busy1, ov1, dn1, fl1, tr1, 1024'(cand1), 1024'(od1));
    m_cmp("d2", m2, MT2, sat2, rdy2, busy2, ov2, dn2, fl2, tr2, 1024'(cand2), 1024'(od2));
    if (dn1 === 1'b1) begin
      if (dn1_cnt < 8) od_hist[dn1_cnt] = od1[63:0];
      dn1_cnt++;
    end
    if (fl1 === 1'b1) fl1_cyc = cyc;
    if (fl2 === 1'b1) fl2_cyc = cyc;
    if (ov2 === 1'b1) ov2_seen++;
    @(posedge clk);
    if (rst1) m_step(m1, CW1, MT1, st1, sat1, rdy1);
    if (rst2) m_step(m2, CW2, MT2, st2, sat2, rdy2);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int s0;
    rst1 = 0; rst2 = 0; st1 = 0; sat1 = 0; rdy1 = 0; st2 = 0; sat2 = 0; rdy2 = 0;
    dn1_cnt = 0; fl1_cyc = -1; fl2_cyc = -1; ov2_seen = 0;
    m_rst(m1, 64'h1); m_rst(m2, 64'h0);
    @(negedge clk); #1;
    chk("rst.busy", 64'(busy1), 64'h0);
    chk("rst.out_valid", 64'(ov1), 64'h0);
    chk("rst.tries", 64'(tr1), 64'h0);
    chk("rst.cand", cand1[63:0], 64'h0);
    chk("rst2.busy", 64'(busy2), 64'h0);
    rst1 = 1; rst2 = 1;

    // First sample, then a 5-cycle stall before the handshake
    sat1 = 1; rdy1 = 0; st1 = 1; step(); st1 = 0;
    repeat (9) step();
    chk("a.valid_c10", 64'(ov1), 64'h1);
    chk("a.cand_w0", cand1[63:0], 64'h1);
    chk("a.cand_w1", cand1[127:64], 64'h2);
    chk("a.cand_w7", 64'(cand1[455:448]), 64'h80);
    chk("a.tries", 64'(tr1), 64'h1);
    dn1_cnt = 0;
    repeat (5) step();
    chk("a.no_early_done", 64'(dn1_cnt), 64'h0);
    chk("a.od_stable", od1[63:0], 64'h1);
    rdy1 = 1; #1;
    chk("a.done_hs", 64'(dn1), 64'h1);
    step(); rdy1 = 0;
    chk("a.done_once", 64'(dn1_cnt), 64'h1);
    chk("a.idle_after", 64'(busy1), 64'h0);

    // start held high: one request per IDLE visit, sequence continues
    st1 = 1; sat1 = 1; rdy1 = 1; dn1_cnt = 0;
    repeat (22) step();
    st1 = 0; rdy1 = 0; step();
    chk("b.req_cnt", 64'(dn1_cnt), 64'h2);
    chk("b.sample1", od_hist[0], 64'h100);
    chk("b.sample2", od_hist[1], 64'h10000);

    // Reset in the 4th FILL cycle, then replay from the seed
    sat1 = 1; st1 = 1; step(); st1 = 0;
    repeat (3) step();
    rst1 = 0; #1;
    m_rst(m1, 64'h1);
    chk("c.busy", 64'(busy1), 64'h0);
    chk("c.fail", 64'(fl1), 64'h0);
    chk("c.done", 64'(dn1), 64'h0);
    chk_w("c.cand", 1024'(cand1), '0);
    chk("c.tries", 64'(tr1), 64'h0);
    rst1 = 1;
    st1 = 1; step(); st1 = 0;
    repeat (9) step();
    chk("c.replay_w0", cand1[63:0], 64'h1);
    chk("c.replay_valid", 64'(ov1), 64'h1);
    rdy1 = 1; step(); rdy1 = 0; step();

    // Narrow candidate, MAX_TRIES=4, checker always rejects
    sat2 = 0; ov2_seen = 0; fl2_cyc = -1;
    s0 = cyc; st2 = 1; step(); st2 = 0;
    repeat (2) step();
    chk("d.c1_w0", cand2[63:0], 64'h1);
    chk("d.c1_w1", 64'(cand2[69:64]), 64'h2);
    repeat (9) step();
    chk("d.c4_w0", cand2[63:0], 64'h40);
    chk("d.c4_w1_trunc", 64'(cand2[69:64]), 64'h0);
    chk("d.fail_now", 64'(fl2), 64'h1);
    chk("d.tries_in_check", 64'(tr2), 64'h3);
    step();
    chk("d.fail_cycle", 64'(fl2_cyc - s0), 64'd12);
    chk("d.busy_after", 64'(busy2), 64'h0);
    chk("d.tries_after", 64'(tr2), 64'h4);
    chk("d.never_valid", 64'(ov2_seen), 64'h0);

    // Default MAX_TRIES exhausted
    sat1 = 0; fl1_cyc = -1;
    s0 = cyc; st1 = 1; step(); st1 = 0;
    for (int i = 0; i < 9300 && fl1_cyc < 0; i++) step();
    chk("e.fail_cycle", 64'(fl1_cyc - s0), 64'd9216);
    step();
    chk("e.tries", 64'(tr1), 64'd1024);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      st1 = ($urandom_range(3) == 0); sat1 = ($urandom_range(2) == 0); rdy1 = 1'($urandom_range(1));
      st2 = ($urandom_range(3) == 0); sat2 = ($urandom_range(3) == 0); rdy2 = 1'($urandom_range(1));
      if ($urandom_range(499) == 0) begin
        rst1 = 0; #1; m_rst(m1, 64'h1);
        chk("r.rst1_busy", 64'(busy1), 64'h0);
        rst1 = 1;
      end
      if ($urandom_range(499) == 0) begin
        rst2 = 0; #1; m_rst(m2, 64'h0);
        chk("r.rst2_busy", 64'(busy2), 64'h0);
        rst2 = 1;
      end
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
